fc_vector_feeder: RTL and testbench

FC_VECTOR_FEEDER -- requirements
Module: fc_vector_feeder

---
 rtl/fc_pkg.sv | 20 ++
 rtl/fc_lane_packer.sv | 30 +++
 rtl/fc_vector_feeder.sv | 100 ++++++++++
 tb/tb_fc_vector_feeder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// fc_pkg: shared defaults, FSM state type and index-width helper for the FC vector feeder
package fc_pkg;

    localparam int FC_DATA_W = 8;
    localparam int FC_N_ELEM = 8;

    typedef enum logic [1:0] {
        FILL,
        ISSUE,
        CAPT,
        HOLD
    } fc_state_t;

    function automatic int fc_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int FC_IDX_W = fc_idx_w(FC_N_ELEM);

endpackage

// File: rtl/fc_lane_packer.sv
// fc_lane_packer: serial-to-parallel packer writing one DATA_W lane of a vector register per enable
module fc_lane_packer
    import fc_pkg::*;
#(
    parameter int DATA_W = FC_DATA_W,
    parameter int N_ELEM = FC_N_ELEM,
    parameter int IDX_W  = fc_idx_w(N_ELEM)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_we,
    input  logic [IDX_W-1:0]         i_idx,
    input  logic [DATA_W-1:0]        i_data,
    output logic [N_ELEM*DATA_W-1:0] o_vec
);

    logic [N_ELEM*DATA_W-1:0] r_vec;

    // write the addressed lane only on an accepted element; all other lanes hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec <= '0;
        end else if (i_we) begin
            r_vec[i_idx*DATA_W +: DATA_W] <= i_data;
        end
    end

    assign o_vec = r_vec;

endmodule

// File: rtl/fc_vector_feeder.sv
// fc_vector_feeder: collects N_ELEM pixel/weight pairs, presents them to a neuron and captures its result
module fc_vector_feeder
    import fc_pkg::*;
#(
    parameter int DATA_W = FC_DATA_W,
    parameter int N_ELEM = FC_N_ELEM
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_pixel,
    input  logic [DATA_W-1:0]        in_weight,
    output logic [N_ELEM*DATA_W-1:0] nrn_pixels,
    output logic [N_ELEM*DATA_W-1:0] nrn_weight,
    input  logic [DATA_W-1:0]        nrn_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     busy
);

    localparam int               IDX_W = fc_idx_w(N_ELEM);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(N_ELEM - 1);

    fc_state_t          r_state;
    logic [IDX_W-1:0]   r_idx;
    logic               r_out_valid;
    logic [DATA_W-1:0]  r_out_data;
    logic               w_accept;

    assign in_ready  = (r_state == FILL);
    assign w_accept  = in_valid && in_ready;
    assign busy      = !((r_state == FILL) && (r_idx == '0));
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    fc_lane_packer #(
        .DATA_W (DATA_W),
        .N_ELEM (N_ELEM),
        .IDX_W  (IDX_W)
    ) u_pix_packer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_we   (w_accept),
        .i_idx  (r_idx),
        .i_data (in_pixel),
        .o_vec  (nrn_pixels)
    );

    fc_lane_packer #(
        .DATA_W (DATA_W),
        .N_ELEM (N_ELEM),
        .IDX_W  (IDX_W)
    ) u_wgt_packer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_we   (w_accept),
        .i_idx  (r_idx),
        .i_data (in_weight),
        .o_vec  (nrn_weight)
    );

    // sequencer: fill lanes, give the neuron one cycle to register, capture its result, hold until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= FILL;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        r_idx   <= (r_idx == LAST) ? '0 : r_idx + 1'b1;
                        r_state <= (r_idx == LAST) ? ISSUE : FILL;
                    end
                end
                ISSUE: begin
                    r_state <= CAPT;
                end
                CAPT: begin
                    r_out_data  <= nrn_result;
                    r_out_valid <= 1'b1;
                    r_state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= FILL;
                    end
                end
                default: begin
                    r_state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc_vector_feeder.sv
// tb_fc_vector_feeder: directed table-driven bench with a registered neuron stub
module tb_fc_vector_feeder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_pixel;
    logic [7:0]  in_weight;
    logic [63:0] nrn_pixels;
    logic [63:0] nrn_weight;
    logic [7:0]  nrn_result;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        busy;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [63:0] pix;
        logic [63:0] wt;
        logic [7:0]  exp;
        bit          gaps;
        int          hold;
    } vec_t;

    vec_t tbl[5];

    fc_vector_feeder #(.DATA_W(8), .N_ELEM(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pixel   (in_pixel),
        .in_weight  (in_weight),
        .nrn_pixels (nrn_pixels),
        .nrn_weight (nrn_weight),
        .nrn_result (nrn_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] dot8(input logic [63:0] p, input logic [63:0] w);
        logic [7:0] s;
        s = 8'd0;
        for (int i = 0; i < 8; i++) s = s + 8'(p[i*8 +: 8] * w[i*8 +: 8]);
        return s;
    endfunction

    // neuron stub: registered dot product, one cycle of latency
    always_ff @(posedge clk) nrn_result <= dot8(nrn_pixels, nrn_weight);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fill(input logic [63:0] pix, input logic [63:0] wt, input bit gaps, input int n, input bit clean);
        int budget;
        logic [63:0] snap;
        for (int i = 0; i < n; i++) begin
            in_valid  = 1'b1;
            in_pixel  = pix[i*8 +: 8];
            in_weight = wt[i*8 +: 8];
            budget = 0;
            while (!in_ready && budget < 20) begin
                @(posedge clk); #1;
                budget++;
            end
            chk("accept_wait", 64'(in_ready), 64'd1);
            @(posedge clk); #1;
            if (clean) chk("clean_slots", nrn_pixels, pix & ((64'h1 << ((i + 1) * 8)) - 64'h1));
            if (gaps && i < n - 1) begin
                snap      = nrn_pixels;
                in_valid  = 1'b0;
                in_pixel  = 8'($urandom);
                in_weight = 8'($urandom);
                @(posedge clk); #1;
                chk("gap_hold", nrn_pixels, snap);
                chk("gap_busy", 64'(busy), 64'd1);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic expect_res(input vec_t v);
        chk("vec_pix", nrn_pixels, v.pix);
        chk("vec_wt", nrn_weight, v.wt);
        chk("issue_valid", 64'(out_valid), 64'd0);
        chk("issue_ready", 64'(in_ready), 64'd0);
        chk("issue_busy", 64'(busy), 64'd1);
        if (v.hold > 0) begin
            in_valid  = 1'b1;
            in_pixel  = 8'hAA;
            in_weight = 8'h55;
        end
        @(posedge clk); #1;
        chk("capt_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk("res_valid", 64'(out_valid), 64'd1);
        chk("res_data", 64'(out_data), 64'(v.exp));
    endtask

    task automatic handshake(input vec_t v);
        out_ready = (v.hold == 0);
        for (int k = 0; k < v.hold; k++) begin
            @(posedge clk); #1;
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", 64'(out_data), 64'(v.exp));
            chk("hold_ready", 64'(in_ready), 64'd0);
            chk("hold_pix", nrn_pixels, v.pix);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk); #1;
        chk("done_valid", 64'(out_valid), 64'd0);
        chk("done_ready", 64'(in_ready), 64'd1);
        chk("done_busy", 64'(busy), 64'd0);
        chk("done_pix", nrn_pixels, v.pix);
    endtask

    initial begin
        tbl[0] = '{64'h0807060504030201, 64'h0101010101010101, 8'h24, 1'b0, 0};
        tbl[1] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 8'h08, 1'b0, 0};
        tbl[2] = '{64'h0706050403020100, 64'h0102030405060708, 8'h54, 1'b0, 5};
        tbl[3] = '{64'h0101010101010101, 64'h0202020202020202, 8'h10, 1'b1, 0};
        tbl[4] = '{64'h0303030303030303, 64'h0101010101010101, 8'h18, 1'b0, 0};
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_pixel  = 8'h00;
        in_weight = 8'h00;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_pix", nrn_pixels, 64'd0);
        chk("rst_wt", nrn_weight, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        for (int t = 0; t < 4; t++) begin
            fill(tbl[t].pix, tbl[t].wt, tbl[t].gaps, 8, t == 0);
            expect_res(tbl[t]);
            handshake(tbl[t]);
        end
        fill(64'h5555555555555555, 64'h7777777777777777, 1'b0, 3, 1'b0);
        chk("mid_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_pix", nrn_pixels, 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        fill(tbl[4].pix, tbl[4].wt, 1'b0, 8, 1'b1);
        expect_res(tbl[4]);
        handshake(tbl[4]);
        fill(tbl[0].pix, tbl[0].wt, 1'b0, 8, 1'b0);
        expect_res(tbl[0]);
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("hold_rst_valid", 64'(out_valid), 64'd0);
        chk("hold_rst_data", 64'(out_data), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("hold_rst_ready", 64'(in_ready), 64'd1);
        chk("hold_rst_busy", 64'(busy), 64'd0);
        fill(tbl[1].pix, tbl[1].wt, 1'b0, 8, 1'b1);
        expect_res(tbl[1]);
        handshake(tbl[1]);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
